// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the CPU's single unified memory port between the instruction-fetch
// requester and the load/store (data) requester. Only one transaction is
// outstanding at a time. A winner's request fields are latched into the
// registered o_mem_* outputs and held stable until the memory accepts them.
// Read data is registered and returned to whichever requester owns the
// transaction.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined     -> round-robin arbitration. On simultaneous requests, the
//                  requester that was not granted last wins. There is no
//                  starvation counter in this mode.
//   not defined -> fixed priority. Data wins over fetch. After STARVE_MAX
//                  consecutive data grants while fetch waits, fetch wins
//                  the next arbitration.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width. Byte enables are DATA_W/8 wide.
//   STARVE_MAX  data grants allowed while fetch waits (1..15). Used only in
//               fixed-priority mode.
//
// Ports
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_if_req / i_if_addr             fetch read request (held until o_if_gnt)
//   o_if_gnt                         fetch request accepted by memory
//   o_if_rvalid / o_if_rdata         one-cycle fetch read-data pulse
//   i_d_req / i_d_we / i_d_addr /
//   i_d_wdata / i_d_be               data request (held until o_d_gnt)
//   o_d_gnt                          data request accepted by memory
//   o_d_rvalid / o_d_rdata           one-cycle load read-data pulse
//   o_mem_req / o_mem_we / o_mem_addr /
//   o_mem_wdata / o_mem_be           registered memory-side request
//   i_mem_ready                      memory accepts the request this cycle
//   i_mem_rvalid / i_mem_rdata       memory read response
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    // Fetch requester
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_W-1:0]     o_if_rdata,

    // Data (load/store) requester
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_be,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_W-1:0]     o_d_rdata,

    // Memory side
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    // The data requester is encoded as 0 so that the owner resets to data.
    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_e;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_e              state_q;
    owner_e              owner_q;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;

    logic                if_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                d_rvalid_q;
    logic [DATA_W-1:0]   d_rdata_q;

    // Memory accepted the request that is on the port this cycle.
    logic                accept;
    // Arbitration result. It is only used in IDLE when at least one request is up.
    logic                pick_fetch;

    assign accept = (state_q == ST_ISSUE) && i_mem_ready;

    // ------------------------------------------------------------------------
    // Arbitration policy
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN

    // Requester that received the most recent grant. It resets to fetch so
    // that data wins the first contested arbitration.
    owner_e last_q;

    // NOTE: every signal assigned in always_comb gets a default at the top.
    // If any path leaves it unassigned, a latch is inferred.
    always_comb begin
        pick_fetch = i_if_req;
        if (i_if_req && i_d_req) begin
            pick_fetch = (last_q == OWN_DATA);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // always_ff block sees the pre-edge values, whatever the evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_q <= OWN_FETCH;
        end else if (accept) begin
            last_q <= owner_q;
        end
    end

`else

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Counts data grants that happened while fetch was waiting.
    logic [3:0] starve_cnt_q;

    // NOTE: every signal assigned in always_comb gets a default at the top.
    // If any path leaves it unassigned, a latch is inferred.
    always_comb begin
        pick_fetch = 1'b0;
        if (i_if_req) begin
            pick_fetch = !i_d_req || (starve_cnt_q == STARVE_LIM);
        end
    end

    // The counter saturates at the limit. Fetch can start requesting while a
    // data request is already in ISSUE. If the counter stepped past the limit
    // in that case, the equality test would never match again.
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // always_ff block sees the pre-edge values, whatever the evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_cnt_q <= 4'd0;
        end else if (accept) begin
            if (owner_q == OWN_FETCH) begin
                starve_cnt_q <= 4'd0;
            end else if (i_if_req && (starve_cnt_q < STARVE_LIM)) begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end
    end

`endif

    // ------------------------------------------------------------------------
    // Transaction FSM with registered memory-side and read-data outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // Reset also aborts an in-flight transaction. A response that
            // arrives afterwards lands in IDLE and is ignored.
            state_q     <= ST_IDLE;
            owner_q     <= OWN_DATA;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            // rvalid outputs are single-cycle pulses. rdata holds its value.
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_if_req || i_d_req) begin
                        mem_req_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                        if (pick_fetch) begin
                            // Fetches are always full-word reads.
                            owner_q     <= OWN_FETCH;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= i_if_addr;
                            mem_wdata_q <= '0;
                            mem_be_q    <= '1;
                        end else begin
                            owner_q     <= OWN_DATA;
                            mem_we_q    <= i_d_we;
                            mem_addr_q  <= i_d_addr;
                            mem_wdata_q <= i_d_wdata;
                            mem_be_q    <= i_d_be;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Fields stay frozen until the memory takes them.
                    if (i_mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_we_q ? ST_IDLE : ST_WAIT_RSP;
                    end
                end

                ST_WAIT_RSP: begin
                    if (i_mem_rvalid) begin
                        if (owner_q == OWN_FETCH) begin
                            if_rdata_q  <= i_mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end else begin
                            d_rdata_q   <= i_mem_rdata;
                            d_rvalid_q  <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Grants are combinational. Each one pulses in the cycle that the memory
    // accepts the owner's request.
    assign o_if_gnt    = accept && (owner_q == OWN_FETCH);
    assign o_d_gnt     = accept && (owner_q == OWN_DATA);

    assign o_if_rvalid = if_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_rvalid  = d_rvalid_q;
    assign o_d_rdata   = d_rdata_q;

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;

endmodule
